// File: rtl/cellrv32_npu_activation_unit.sv
// NPU activation datapath: per-lane round-out-of-fixed-point, activation function, byte saturation.
// Three registered stages; a shared control pipe carries func, signed and valid alongside each row.
module cellrv32_npu_activation_unit #(
  parameter int MATRIX_WIDTH         = 14,
  parameter int ACC_WIDTH            = 32,
  parameter int DATA_WIDTH           = 8,
  parameter int FRAC_BITS            = 8,
  parameter int ACTIVATION_BIT_WIDTH = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 enable_i,
  input  logic [ACTIVATION_BIT_WIDTH-1:0]      activation_func_i,
  input  logic                                 signed_unsigned_i,
  input  logic                                 valid_i,
  input  logic [MATRIX_WIDTH*ACC_WIDTH-1:0]    acc_data_i,
  output logic [MATRIX_WIDTH*DATA_WIDTH-1:0]   act_data_o,
  output logic                                 valid_o
);

  localparam int EW = ACC_WIDTH + 1;

  localparam logic        [EW-1:0] HALF  = EW'(2 ** (FRAC_BITS - 1));
  localparam logic signed [EW-1:0] ZERO  = '0;
  localparam logic signed [EW-1:0] ONE   = EW'(1);
  localparam logic signed [EW-1:0] M_ONE = '1;
  localparam logic signed [EW-1:0] SIX   = EW'(6);
  localparam logic signed [EW-1:0] S_MAX = EW'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [EW-1:0] S_MIN = ~S_MAX;
  localparam logic signed [EW-1:0] U_MAX = EW'(2 ** DATA_WIDTH - 1);

  localparam logic [DATA_WIDTH-1:0] S_MAX_B = S_MAX[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] S_MIN_B = S_MIN[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] U_MAX_B = U_MAX[DATA_WIDTH-1:0];

  localparam logic [ACTIVATION_BIT_WIDTH-1:0] F_RELU  = ACTIVATION_BIT_WIDTH'(1);
  localparam logic [ACTIVATION_BIT_WIDTH-1:0] F_RELU6 = ACTIVATION_BIT_WIDTH'(2);
  localparam logic [ACTIVATION_BIT_WIDTH-1:0] F_HTANH = ACTIVATION_BIT_WIDTH'(3);

  // Shared control pipe: func is only needed by stage 2, signed by stages 2 and 3.
  logic [ACTIVATION_BIT_WIDTH-1:0] func_q1;
  logic                            sgn_q1, sgn_q2;
  logic                            valid_q1, valid_q2, valid_q3;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      func_q1  <= '0;
      sgn_q1   <= 1'b0;
      sgn_q2   <= 1'b0;
      valid_q1 <= 1'b0;
      valid_q2 <= 1'b0;
      valid_q3 <= 1'b0;
    end else if (enable_i) begin
      func_q1  <= activation_func_i;
      sgn_q1   <= signed_unsigned_i;
      sgn_q2   <= sgn_q1;
      valid_q1 <= valid_i;
      valid_q2 <= valid_q1;
      valid_q3 <= valid_q2;
    end
  end

  assign valid_o = valid_q3;

  for (genvar i = 0; i < MATRIX_WIDTH; i++) begin : g_lane
    logic [ACC_WIDTH-1:0]   acc;
    logic [EW-1:0]          x_ext, sum;
    logic signed [EW-1:0]   r_d, r_q, f_d, f_q;
    logic [DATA_WIDTH-1:0]  sat_d, out_q;

    assign acc = acc_data_i[i*ACC_WIDTH +: ACC_WIDTH];

    // The extra top bit absorbs the rounding carry in both signed and unsigned modes.
    always_comb begin
      x_ext = signed_unsigned_i ? {acc[ACC_WIDTH-1], acc} : {1'b0, acc};
      sum   = x_ext + HALF;
      r_d   = signed_unsigned_i ? ($signed(sum) >>> FRAC_BITS) : $signed(sum >> FRAC_BITS);
    end

    // Unsigned r is never negative, so the max(r,0) terms reduce to no-ops there.
    always_comb begin
      f_d = r_q;
      case (func_q1)
        F_RELU:  f_d = (r_q < ZERO) ? ZERO : r_q;
        F_RELU6: f_d = (r_q < ZERO) ? ZERO : ((r_q > SIX) ? SIX : r_q);
        F_HTANH: begin
          if (r_q > ONE)                 f_d = ONE;
          else if (sgn_q1 && r_q < M_ONE) f_d = M_ONE;
          else                            f_d = r_q;
        end
        default: f_d = r_q;
      endcase
    end

    always_comb begin
      sat_d = f_q[DATA_WIDTH-1:0];
      if (sgn_q2) begin
        if (f_q > S_MAX)      sat_d = S_MAX_B;
        else if (f_q < S_MIN) sat_d = S_MIN_B;
      end else begin
        if (f_q > U_MAX)      sat_d = U_MAX_B;
        else if (f_q < ZERO)  sat_d = '0;
      end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_q   <= '0;
        f_q   <= '0;
        out_q <= '0;
      end else if (enable_i) begin
        r_q   <= r_d;
        f_q   <= f_d;
        out_q <= sat_d;
      end
    end

    assign act_data_o[i*DATA_WIDTH +: DATA_WIDTH] = out_q;
  end

endmodule

// File: tb/tb_cellrv32_npu_activation_unit.sv
// Scoreboard bench for the NPU activation unit: stimulus pushes expected rows, a monitor pops
// one entry per enabled edge and checks holds on stalled edges.
module tb_cellrv32_npu_activation_unit;
  localparam int MW   = 14;
  localparam int AW   = 32;
  localparam int DW   = 8;
  localparam int FRAC = 8;

  logic               clk_i = 1'b0;
  logic               rstn_i;
  logic               enable_i;
  logic [3:0]         activation_func_i;
  logic               signed_unsigned_i;
  logic               valid_i;
  logic [MW*AW-1:0]   acc_data_i;
  logic [MW*DW-1:0]   act_data_o;
  logic               valid_o;

  cellrv32_npu_activation_unit #(
    .MATRIX_WIDTH(MW), .ACC_WIDTH(AW), .DATA_WIDTH(DW), .FRAC_BITS(FRAC), .ACTIVATION_BIT_WIDTH(4)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i),
    .activation_func_i(activation_func_i), .signed_unsigned_i(signed_unsigned_i),
    .valid_i(valid_i), .acc_data_i(acc_data_i), .act_data_o(act_data_o), .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [MW*DW-1:0] d;
    logic             v;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic en_s, rs_s;

  // Reference: floor((x + half) / 2^FRAC), then the named function, then clamp to a byte.
  function automatic logic [7:0] model(logic [31:0] w, logic [3:0] fn, logic s);
    longint x, r, f, half;
    half = longint'(1) << (FRAC - 1);
    x = s ? longint'($signed(w)) : longint'({32'b0, w});
    r = (x + half) >>> FRAC;
    case (fn)
      4'd1:    f = (r > 0) ? r : 0;
      4'd2:    f = (r > 6) ? 6 : ((r > 0) ? r : 0);
      4'd3:    f = (r > 1) ? 1 : ((s && r < -1) ? -1 : r);
      default: f = r;
    endcase
    if (s) f = (f > 127) ? 127 : ((f < -128) ? -128 : f);
    else   f = (f > 255) ? 255 : ((f < 0) ? 0 : f);
    return f[7:0];
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] ext[6];
    ext = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0000_7F80, 32'h0000_0080};
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
      2:       return ext[$urandom_range(0, 5)];
      default: return 32'($urandom_range(0, 2047));
    endcase
  endfunction

  function automatic logic [MW*AW-1:0] rand_row();
    logic [MW*AW-1:0] d;
    for (int l = 0; l < MW; l++) d[l*AW +: AW] = rand_word();
    return d;
  endfunction

  function automatic logic [MW*AW-1:0] fill_row(logic [31:0] w);
    logic [MW*AW-1:0] d;
    for (int l = 0; l < MW; l++) d[l*AW +: AW] = w;
    return d;
  endfunction

  task automatic check_out(string name, logic [MW*DW-1:0] ed, logic ev);
    n_tests++;
    if (act_data_o !== ed || valid_o !== ev) begin
      n_fail++;
      $display("FAIL %s: got data=%h valid=%b, expected data=%h valid=%b",
               name, act_data_o, valid_o, ed, ev);
    end
  endtask

  // One input cycle; an enabled cycle is always captured, so it always gets a scoreboard entry.
  task automatic cycle(bit en, bit v, logic [3:0] fn, bit s, logic [MW*AW-1:0] d,
                       bit use0, logic [7:0] e0);
    exp_t e;
    @(negedge clk_i);
    enable_i = en; valid_i = v; activation_func_i = fn; signed_unsigned_i = s; acc_data_i = d;
    if (en) begin
      for (int l = 0; l < MW; l++) e.d[l*DW +: DW] = model(d[l*AW +: AW], fn, s);
      if (use0) e.d[7:0] = e0;
      e.v = v;
      q.push_back(e);
    end
  endtask

  task automatic row(logic [3:0] fn, bit s, logic [31:0] w0, logic [7:0] e0);
    logic [MW*AW-1:0] d;
    d = rand_row();
    d[AW-1:0] = w0;
    cycle(1'b1, 1'b1, fn, s, d, 1'b1, e0);
  endtask

  // After reset the pipeline holds two zero rows ahead of anything newly presented.
  task automatic model_reset();
    exp_t z;
    z.d = '0; z.v = 1'b0;
    q.delete();
    q.push_back(z);
    q.push_back(z);
    last_exp = z;
  endtask

  task automatic do_reset(string name);
    @(negedge clk_i);
    rstn_i = 1'b0;
    enable_i = 1'b0;
    valid_i = 1'b1;
    acc_data_i = rand_row();
    #1;
    check_out(name, '0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk_i);
    check_out({name, "_held"}, '0, 1'b0);
    rstn_i = 1'b1;
  endtask

  always @(posedge clk_i) begin
    exp_t e;
    en_s = enable_i;
    rs_s = rstn_i;
    #1;
    if (rs_s && rstn_i) begin
      if (en_s) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL scoreboard_underflow: got data=%h valid=%b, expected no output", act_data_o, valid_o);
        end else begin
          e = q.pop_front();
          check_out("row", e.d, e.v);
          last_exp = e;
        end
      end else begin
        check_out("stall_hold", last_exp.d, last_exp.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    rstn_i = 1'b0; enable_i = 1'b0; valid_i = 1'b0; activation_func_i = '0;
    signed_unsigned_i = 1'b0; acc_data_i = '0;
    #2;
    check_out("reset_state", '0, 1'b0);
    model_reset();
    @(negedge clk_i);
    rstn_i = 1'b1;

    // Rounding and function selection
    row(4'd0, 1'b1, 32'h0000_0380, 8'h04);
    row(4'd0, 1'b1, 32'hFFFF_FE80, 8'hFF);
    row(4'd1, 1'b1, 32'hFFFF_FE80, 8'h00);
    row(4'd2, 1'b1, 32'h0000_1000, 8'h06);
    row(4'd3, 1'b1, 32'hFFFF_0000, 8'hFF);
    row(4'd10, 1'b1, 32'h0000_0380, 8'h04);
    // Saturation
    row(4'd0, 1'b1, 32'h7FFF_FFFF, 8'h7F);
    row(4'd0, 1'b1, 32'h8000_0000, 8'h80);
    row(4'd0, 1'b0, 32'hFFFF_FFFF, 8'hFF);
    row(4'd1, 1'b0, 32'h8000_0000, 8'hFF);
    // Alternating func on back-to-back rows, all lanes equal
    for (int k = 0; k < 6; k++)
      cycle(1'b1, 1'b1, (k % 2 == 0) ? 4'd1 : 4'd0, 1'b1, fill_row(32'hFFFF_FE80),
            1'b1, (k % 2 == 0) ? 8'h00 : 8'hFF);
    // Rows 1..5 with a 4-cycle stall after row 3 (garbage inputs while stalled)
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b1, 1'b1, 4'd0, 1'b1, fill_row(32'(k) << FRAC), 1'b1, 8'(k));
      if (k == 3)
        repeat (4) cycle(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'($urandom), rand_row(), 1'b0, 8'h00);
    end
    repeat (3) cycle(1'b1, 1'b0, 4'd0, 1'b1, '0, 1'b0, 8'h00);
    // Reset with two rows in flight
    row(4'd0, 1'b1, 32'h0000_0380, 8'h04);
    row(4'd0, 1'b1, 32'h0000_0480, 8'h05);
    do_reset("reset_in_flight");
    row(4'd2, 1'b1, 32'h0000_0280, 8'h03);
    repeat (3) cycle(1'b1, 1'b0, 4'd0, 1'b0, '0, 1'b0, 8'h00);
    // Randomized traffic with random stalls and bubbles
    for (int k = 0; k < 300; k++)
      cycle(($urandom_range(0, 4) != 0), 1'($urandom), 4'($urandom_range(0, 15)), 1'($urandom),
            rand_row(), 1'b0, 8'h00);
    repeat (4) cycle(1'b1, 1'b0, 4'd0, 1'b0, '0, 1'b0, 8'h00);
    @(negedge clk_i);
    enable_i = 1'b0;
    @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cellrv32_npu_activation_unit.md
Name: cellrv32_npu_activation_unit

Overview:
Per-lane datapath stage directly downstream of the NPU activation control unit. Each cycle it takes one row of MATRIX_WIDTH accumulator words from the register file. It rounds each word out of fixed point, applies the activation function selected by the control unit, and saturates the result to a byte. The byte row goes to the unified buffer write port. The function code and signed flag arrive aligned with the data and travel down a 3-stage pipeline with it.

Parameters:
MATRIX_WIDTH, 14, number of parallel lanes
ACC_WIDTH, 32, accumulator word width per lane
DATA_WIDTH, 8, output byte width per lane
FRAC_BITS, 8, fractional bits in the accumulator word; legal range 1..ACC_WIDTH-1

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset; asynchronous, active-low
enable_i  in  1  pipeline advance; when low, all stages hold
activation_func_i  in  ACTIVATION_BIT_WIDTH(4)  function code, aligned with acc_data_i
signed_unsigned_i  in  1  1 = signed data, 0 = unsigned data; aligned with acc_data_i
valid_i  in  1  row valid tag; carried through the pipeline for bench and debug use
acc_data_i  in  MATRIX_WIDTH*ACC_WIDTH  accumulator row; lane i is bits [i*ACC_WIDTH +: ACC_WIDTH]
act_data_o  out  MATRIX_WIDTH*DATA_WIDTH  activated byte row; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH]
valid_o  out  1  valid_i delayed by 3 enabled cycles

Behaviour:
- Reset: every pipeline register clears to 0, including func, signed and valid. act_data_o = 0 and valid_o = 0.
- Latency: exactly 3 enabled clock edges from input to act_data_o and valid_o. All outputs are registered; there is no combinational input-to-output path.
- enable_i = 0: no register updates. Outputs are stable. No data is lost or duplicated, so a stall of N cycles adds exactly N cycles of latency.
- Stage 1 (round):
  - Extend x to ACC_WIDTH+1 bits: sign-extend if signed, zero-extend if unsigned.
  - r = (x + 2^(FRAC_BITS-1)) >> FRAC_BITS. The shift is arithmetic if signed, logical if unsigned.
  - The add cannot overflow because of the extra bit.
  - Register r, func, signed and valid.
- Stage 2 (function), on r:
  - 0000 none: f = r.
  - 0001 ReLU: f = max(r,0).
  - 0010 ReLU6: f = min(max(r,0),6).
  - 0011 hard-tanh: f = clamp(r,-1,1) if signed; f = min(r,1) if unsigned.
  - 0100..1111: reserved, behave exactly as 0000.
  - In unsigned mode, ReLU is a no-op.
- Stage 3 (saturate):
  - Signed: clamp f to [-128,127], output two's complement.
  - Unsigned: clamp f to [0,255].
  - Register the result into act_data_o.
- Func and signed are sampled per row. Changing them on consecutive rows affects only the row they accompany, with no bleed into neighbouring rows.
- Lanes are fully independent and share only the func and signed controls.
- Reset asserted mid-operation clears all in-flight rows immediately. The first output after reset release reflects only rows presented after release.
- Target RTL size: 150–250 lines; one generate loop over lanes plus a shared control pipe.

Test Plan:
1. Signed, func 0000, lane0 = 0x00000380 -> after 3 cycles lane0 = 0x04 (3.5 rounds up) and valid_o = 1. Lane0 = 0xFFFFFE80 -> 0xFF (-1).
2. Signed, lane0 = 0xFFFFFE80: func 0001 -> 0x00. Func 0010 with lane0 = 0x00001000 -> 0x06. Func 0011 with lane0 = 0xFFFF0000 -> 0xFF. Func 1010 (reserved) with lane0 = 0x00000380 -> 0x04.
3. Saturation:
   - Signed, func 0000: 0x7FFFFFFF -> 0x7F; 0x80000000 -> 0x80.
   - Unsigned, func 0000: 0xFFFFFFFF -> 0xFF.
   - Unsigned, func 0001: 0x80000000 -> 0xFF (no ReLU clipping).
4. Back-to-back rows with func alternating 0001/0000 and every lane = 0xFFFFFE80 -> outputs alternate 0x00/0xFF on consecutive cycles; every lane equal.
5. Stream rows 1..5 with enable_i low for 4 cycles mid-stream -> outputs and valid_o hold during the stall. The rows emerge in order, none lost or repeated, with total latency 3 + 4.
6. Assert rstn_i with 2 rows in flight -> act_data_o = 0 and valid_o = 0 at once. No stale row appears after release.
